// File: rtl/uart_tx.sv
// uart_tx -- byte-parallel to serial UART transmitter.
//
// Accepts one word per valid/ready handshake and shifts it out as an
// asynchronous frame: one start bit (0), DATA_BITS data bits LSB first,
// an optional even-parity bit, then STOP_BITS stop bits (1). Bit timing
// comes from an internal divider counter, so no external baud tick is needed.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after the data bits. With the macro undefined, the parity state and its
// register are not built.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   DATA_BITS     data bits per frame (5..8)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports:
//   clk       in   single clock, rising-edge active
//   rst_n     in   asynchronous active-low reset
//   tx_data   in   word to send; sampled only on an accepting edge
//   tx_valid  in   upstream presents tx_data
//   tx_ready  out  block accepts a word this cycle (registered)
//   tx        out  serial line, idle high (registered)
//   busy      out  frame in progress, inverse of tx_ready (registered)

module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PAR   = 3'd3,
`endif
    S_STOP  = 3'd4
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
`endif

  // Last cycle of the current bit period.
  logic w_bit_end;
  assign w_bit_end = (r_cnt == CNT_LAST);

  // All outputs come straight from flops. r_tx is loaded with the value of
  // the *next* bit on the edge that ends the current one, so the line
  // changes exactly on bit-period boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          if (tx_valid && r_ready) begin
            r_shift <= tx_data;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^tx_data;
`endif
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= S_PAR;
`else
              r_tx    <= 1'b1;
              r_stop  <= 1'b0;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + BW'(1);
              // Bit 1 is the next bit out once the register has shifted.
              r_tx  <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PAR: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_stop  <= 1'b0;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif

        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_stop == STOP_LAST) begin
              // Ready rises in the cycle after the last stop cycle.
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_stop <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int C  = 4;
  localparam int DB = 8;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P  = 1;
`else
  localparam int P  = 0;
`endif
  localparam int F  = 1 + DB + P + SB;
  localparam int FL = F * C;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          tx;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic obs_tx   [0:511];
  logic obs_rdy  [0:511];
  logic obs_busy [0:511];

  uart_tx #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference: value of frame bit slot 'slot' for word d.
  function automatic logic model_bit(input logic [7:0] d, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= DB) return d[slot-1];
    if (P == 1 && slot == DB + 1) return ^d;
    return 1'b1;
  endfunction

  // Reference receiver: sample mid-bit starting at a captured start index.
  function automatic logic [7:0] decode(input int base);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < DB; i++) b[i] = obs_tx[base + (1 + i) * C + C / 2];
    return b;
  endfunction

  task automatic capture(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_tx[start+i]   = tx;
      obs_rdy[start+i]  = tx_ready;
      obs_busy[start+i] = busy;
    end
  endtask

  // Returns just after the accepting rising edge; bounded.
  task automatic wait_accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1 && tx_valid === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s accept_timeout: tx_ready=%b required 1 within 200 cycles", name, tx_ready);
    end
  endtask

  task automatic test_reset;
    int bad;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: tx=%b rdy=%b busy=%b required 1 1 0", tx, tx_ready, busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_single_frame;
    int bad;
    logic [7:0] d;
    d = 8'h55;
    tx_data = d; tx_valid = 1'b1;
    wait_accept("single");
    #1 tx_valid = 1'b0;
    capture(0, FL + 1);
    checks++;
    if (obs_rdy[0] !== 1'b0 || obs_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_drop: rdy=%b busy=%b required 0 1", obs_rdy[0], obs_busy[0]);
    end
    bad = 0;
    for (int s = 0; s <= DB; s++) if (obs_tx[s*C+1] !== logic'(s % 2)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_0x55_slots: %0d slots wrong, required 0", bad);
    end
    bad = 0;
    for (int k = 0; k < FL; k++) if (obs_tx[k] !== model_bit(d, k / C)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_frame_bits: %0d cycles wrong, required 0", bad);
    end
    checks++;
    if (obs_rdy[FL-1] !== 1'b0 || obs_rdy[FL] !== 1'b1 || obs_tx[FL] !== 1'b1) begin
      errors++;
      $display("FAIL single_length: rdy[%0d]=%b rdy[%0d]=%b tx=%b required 0 1 1",
               FL - 1, obs_rdy[FL-1], FL, obs_rdy[FL], obs_tx[FL]);
    end
    bad = 0;
    for (int k = 0; k <= FL; k++) if (obs_busy[k] !== ~obs_rdy[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_busy_inverse: %0d cycles wrong, required 0", bad);
    end
  endtask

  task automatic test_random_frames;
    logic [7:0] d;
    int bad;
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom_range(0, 255));
      tx_data = d; tx_valid = 1'b1;
      wait_accept("random");
      #1 tx_valid = 1'b0;
      tx_data = 8'($urandom_range(0, 255));
      capture(0, FL + 1);
      bad = 0;
      for (int k = 0; k < FL; k++) if (obs_tx[k] !== model_bit(d, k / C)) bad++;
      if (obs_rdy[FL-1] !== 1'b0 || obs_rdy[FL] !== 1'b1) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random_frame d=%h: %0d wrong, required 0", d, bad);
      end
      checks++;
      if (decode(0) !== d) begin
        errors++;
        $display("FAIL random_decode: got %h required %h", decode(0), d);
      end
    end
  endtask

  task automatic test_parity;
    logic [7:0] vals [2];
    logic [7:0] d;
    vals[0] = 8'h07;
    vals[1] = 8'h03;
    for (int n = 0; n < 2; n++) begin
      d = vals[n];
      tx_data = d; tx_valid = 1'b1;
      wait_accept("parity");
      #1 tx_valid = 1'b0;
      capture(0, FL + 1);
      checks++;
      if (obs_tx[(DB+1)*C+1] !== model_bit(d, DB + 1)) begin
        errors++;
        $display("FAIL parity_slot d=%h: tx=%b required %b", d, obs_tx[(DB+1)*C+1], model_bit(d, DB + 1));
      end
      checks++;
      if (obs_rdy[FL-1] !== 1'b0 || obs_rdy[FL] !== 1'b1) begin
        errors++;
        $display("FAIL parity_length d=%h: rdy_end=%b rdy_after=%b required 0 1", d, obs_rdy[FL-1], obs_rdy[FL]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    tx_data = 8'hA5; tx_valid = 1'b1;
    wait_accept("b2b");
    #1 tx_data = 8'h3C;
    capture(0, 2 * FL + 1);
    tx_valid = 1'b0;
    capture(2 * FL + 1, 3);
    checks++;
    if (obs_tx[FL] !== 1'b1 || obs_rdy[FL] !== 1'b1 || obs_tx[FL+1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: idle tx=%b rdy=%b next tx=%b required 1 1 0",
               obs_tx[FL], obs_rdy[FL], obs_tx[FL+1]);
    end
    bad = 0;
    for (int k = 0; k < FL; k++) begin
      if (obs_tx[k] !== model_bit(8'hA5, k / C)) bad++;
      if (obs_tx[FL+1+k] !== model_bit(8'h3C, k / C)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_bits: %0d cycles wrong, required 0", bad);
    end
    checks++;
    if (decode(0) !== 8'hA5 || decode(FL + 1) !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_decode: got %h %h required a5 3c", decode(0), decode(FL + 1));
    end
    checks++;
    if (obs_rdy[2*FL+1] !== 1'b1 || obs_tx[2*FL+3] !== 1'b1 || obs_rdy[2*FL+3] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: rdy=%b tx=%b required 1 1", obs_rdy[2*FL+3], obs_tx[2*FL+3]);
    end
  endtask

  task automatic test_ignored_input;
    int bad;
    tx_data = 8'hFF; tx_valid = 1'b1;
    wait_accept("ignore");
    #1 tx_valid = 1'b0;
    capture(0, 10);
    tx_data = 8'h00; tx_valid = 1'b1;
    capture(10, 1);
    tx_valid = 1'b0;
    capture(11, FL - 11 + 20);
    bad = 0;
    for (int k = 0; k < FL; k++) if (obs_tx[k] !== model_bit(8'hFF, k / C)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ignore_bits: %0d cycles wrong, required 0", bad);
    end
    bad = 0;
    for (int k = FL; k < FL + 20; k++) if (obs_tx[k] !== 1'b1 || obs_rdy[k] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ignore_no_extra_frame: %0d cycles not idle, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    logic [7:0] d;
    d = 8'($urandom_range(0, 255)) & 8'hF7;
    tx_data = d; tx_valid = 1'b1;
    wait_accept("midrst");
    #1 tx_valid = 1'b0;
    capture(0, 4 * C + 1);
    checks++;
    if (obs_tx[4*C] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_bit3: tx=%b required 0", obs_tx[4*C]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: tx=%b rdy=%b busy=%b required 1 1 0", tx, tx_ready, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture(0, 3 * FL);
    bad = 0;
    for (int k = 0; k < 3 * FL; k++)
      if (obs_tx[k] !== 1'b1 || obs_rdy[k] !== 1'b1 || obs_busy[k] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_idle_after: %0d cycles not idle, required 0", bad);
    end
    d = 8'h96;
    tx_data = d; tx_valid = 1'b1;
    wait_accept("midrst_recover");
    #1 tx_valid = 1'b0;
    capture(0, FL + 1);
    checks++;
    if (decode(0) !== d || obs_rdy[FL] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_recover: got %h rdy=%b required %h 1", decode(0), obs_rdy[FL], d);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_random_frames();
    test_parity();
    test_back_to_back();
    test_ignored_input();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-parallel to serial UART transmitter: accepts one byte per valid/ready handshake and emits an asynchronous frame (start bit, data bits LSB first, optional parity, stop bits) on `tx`. It produces the serial line consumed by the UART receive stage, and drives `tx` from a registered output. Baud timing comes from an internal clock-divider counter, so the block needs no external baud tick.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 2..65535.
- `DATA_BITS`, 8: data bits per frame; legal range 5..8.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  DATA_BITS  byte to send; sampled only on an accepting edge.
- `tx_valid`  in  1  upstream presents `tx_data`.
- `tx_ready`  out  1  block can accept a byte this cycle.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  frame in progress (inverse of `tx_ready`).

## Operation
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - `tx`=1, `tx_ready`=1.
  - On `tx_valid && tx_ready` at an edge: latch `tx_data` into the shift register, clear the baud counter and bit index, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0; the register shifts right at the end of each bit period.
  - After DATA_BITS periods: go to PAR if the parity feature is compiled in, else to STOP.
- PAR: `tx` = parity bit for one bit period, then go to STOP.
- STOP:
  - `tx`=1 for STOP_BITS × CLKS_PER_BIT cycles, then go to IDLE.
  - The stop bit is never shortened.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; the bit period ends on the cycle the counter equals CLKS_PER_BIT-1.
  - Width is $clog2(CLKS_PER_BIT).
  - Wraps to 0 at the end of each bit period.
- Bit index: counts 0..DATA_BITS-1; cleared on entry to DATA.
- Changes to `tx_data` or `tx_valid` while busy are ignored; there is no queuing.
- Reset mid-frame: the line returns high immediately (asynchronous) and the frame is discarded. No partial frame resumes after reset release.

## Timing
- Reset values:
  - `tx`=1, `tx_ready`=1, `busy`=0.
  - FSM=IDLE; counters=0; shift register=0.
- `tx`, `tx_ready` and `busy` are registered; no combinational path from any input to any output.
- Handshake:
  - Transfer occurs on an edge where `tx_valid`=1 and `tx_ready`=1.
  - `tx_ready` drops in the cycle after acceptance.
  - Upstream may hold `tx_valid` high continuously.
- Latency: the falling edge of the start bit appears on `tx` in the first cycle after the accepting edge.
- Frame length:
  - Frame length is F × CLKS_PER_BIT cycles, where F = 1 + DATA_BITS + P + STOP_BITS and P is 1 with parity, 0 without.
  - `tx_ready` rises in the cycle after the last stop-bit cycle.
- Back-to-back: with `tx_valid` held high, the next start bit begins exactly F × CLKS_PER_BIT + 1 cycles after the previous one. This includes one IDLE cycle with `tx`=1.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - PAR state is present.
  - Parity bit is the even parity of the data bits (XOR of all data bits), so the count of ones across data and parity is even.
- Undefined:
  - PAR state, parity logic and parity register are not compiled.
  - DATA transitions directly to STOP.

## Test plan
- Reset idle: assert `rst_n`=0 for 3 cycles, release, hold `tx_valid`=0 for 50 cycles -> `tx`=1, `tx_ready`=1, `busy`=0 throughout.
- Single frame: CLKS_PER_BIT=4, no parity, send 0x55 -> `tx_ready` low 1 cycle after accept; `tx` pattern per 4-cycle slot is 0,1,0,1,0,1,0,1,0,1; `tx_ready` high 40 cycles after first start cycle.
- Parity: with `UART_TX_PARITY_EN` defined, CLKS_PER_BIT=4, send 0x07 -> parity slot `tx`=1; send 0x03 -> parity slot `tx`=0; frame length 44 cycles.
- Back-to-back: hold `tx_valid`=1 with 0xA5 then 0x3C, CLKS_PER_BIT=4, no parity -> second start bit begins 41 cycles after the first. Receiver model decodes 0xA5, 0x3C.
- Ignored input: during a frame of 0xFF, change `tx_data` to 0x00 and pulse `tx_valid` -> transmitted bits remain all ones; no extra frame follows.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 3 -> `tx`=1 asynchronously. After release, `tx` stays high and `tx_ready`=1 until the next valid.
